// File: rtl/hpdmc_initseq.sv
// ----------------------------------------------------------------------------
// hpdmc_initseq
//
// SDRAM power-up / initialisation sequencer. On a start request it holds CKE
// low for the power-up time, raises CKE, then issues the standard JEDEC init
// command train on the SDRAM control bus:
//
//   PRECHARGE ALL, EMRS, MRS (DLL reset), PRECHARGE ALL,
//   AUTO REFRESH, AUTO REFRESH, MRS (normal)
//
// It then waits for DLL lock and reports done. All outputs are registered,
// and a single 16-bit down-counter provides every wait interval.
//
// Parameters
//   T_PWRUP  cycles with CKE low before the command train
//   T_RP     PRECHARGE to next command
//   T_MRD    (E)MRS to next command
//   T_RFC    AUTO REFRESH to next command
//   T_DLL    final MRS to done
//   MR_VAL   mode register value (bit 8 is overridden by the sequencer)
//   EMR_VAL  extended mode register value
//   A timing parameter of 0 behaves as 1.
//
// Ports
//   sys_clk      system clock, rising edge
//   sys_rst_n    asynchronous active-low reset
//   start        single-cycle request to run the sequence (IDLE/DONE only)
//   busy         sequence in progress
//   done         sequence completed, held until next start or reset
//   sdram_cke    SDRAM clock enable
//   sdram_cs_n   chip select
//   sdram_ras_n  RAS
//   sdram_cas_n  CAS
//   sdram_we_n   WE
//   sdram_adr    address / mode bits
//   sdram_ba     bank address
// ----------------------------------------------------------------------------
module hpdmc_initseq #(
    parameter int unsigned T_PWRUP = 20000,
    parameter int unsigned T_RP    = 2,
    parameter int unsigned T_MRD   = 2,
    parameter int unsigned T_RFC   = 8,
    parameter int unsigned T_DLL   = 200,
    parameter logic [12:0] MR_VAL  = 13'h022,
    parameter logic [12:0] EMR_VAL = 13'h000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [12:0] sdram_adr,
    output logic [1:0]  sdram_ba
);

    // Zero-valued timing parameters are promoted to 1.
    localparam int unsigned TPwrup = (T_PWRUP == 0) ? 1 : T_PWRUP;
    localparam int unsigned TRp    = (T_RP    == 0) ? 1 : T_RP;
    localparam int unsigned TMrd   = (T_MRD   == 0) ? 1 : T_MRD;
    localparam int unsigned TRfc   = (T_RFC   == 0) ? 1 : T_RFC;
    localparam int unsigned TDll   = (T_DLL   == 0) ? 1 : T_DLL;

    // Counter reload values. A state that lasts N cycles is entered with N-1
    // and leaves on the cycle it reads 0, so the next command lands exactly
    // N cycles after the current one.
    localparam logic [15:0] LdPwrup = 16'(TPwrup - 1);
    localparam logic [15:0] LdRp    = 16'(TRp - 1);
    localparam logic [15:0] LdMrd   = 16'(TMrd - 1);
    localparam logic [15:0] LdRfc   = 16'(TRfc - 1);
    // The MRS command cycle itself is one of the T_DLL cycles, so DLL_WAIT
    // covers the remaining T_DLL-1 cycles (skipped entirely when T_DLL is 1).
    localparam logic [15:0] LdDll   = (TDll > 1) ? 16'(TDll - 2) : 16'd0;

    localparam logic [12:0] AdrPreAll = 13'h0400;  // A10 selects all banks
    localparam logic [12:0] MrDllRst  = MR_VAL | 13'h0100;
    localparam logic [12:0] MrRun     = MR_VAL & 13'h1eff;

    typedef enum logic [3:0] {
        StIdle,
        StPwrup,
        StCkeNop,
        StPre1,
        StEmrs,
        StMrsDllRst,
        StPre2,
        StRef1,
        StRef2,
        StMrs,
        StDllWait,
        StDone
    } state_e;

    state_e      state;
    logic [15:0] cnt;

    wire cnt_zero = (cnt == 16'd0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= StIdle;
            cnt         <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sdram_cke   <= 1'b0;
            sdram_cs_n  <= 1'b1;
            sdram_ras_n <= 1'b1;
            sdram_cas_n <= 1'b1;
            sdram_we_n  <= 1'b1;
            sdram_adr   <= 13'd0;
            sdram_ba    <= 2'd0;
        end else begin
            // Default bus cycle is a deselect; adr/ba keep their last value.
            sdram_cs_n  <= 1'b1;
            sdram_ras_n <= 1'b1;
            sdram_cas_n <= 1'b1;
            sdram_we_n  <= 1'b1;

            // Saturating countdown; any reload below overrides this.
            if (!cnt_zero) begin
                cnt <= cnt - 16'd1;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StPwrup;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        sdram_cke <= 1'b0;
                        cnt       <= LdPwrup;
                    end
                end

                StPwrup: begin
                    if (cnt_zero) begin
                        state     <= StCkeNop;
                        sdram_cke <= 1'b1;
                        cnt       <= 16'd1;  // two NOP cycles with CKE high
                    end
                end

                StCkeNop: begin
                    if (cnt_zero) begin
                        state       <= StPre1;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_we_n  <= 1'b0;
                        sdram_adr   <= AdrPreAll;
                        sdram_ba    <= 2'b00;
                        cnt         <= LdRp;
                    end
                end

                StPre1: begin
                    if (cnt_zero) begin
                        state       <= StEmrs;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_cas_n <= 1'b0;
                        sdram_we_n  <= 1'b0;
                        sdram_adr   <= EMR_VAL;
                        sdram_ba    <= 2'b01;
                        cnt         <= LdMrd;
                    end
                end

                StEmrs: begin
                    if (cnt_zero) begin
                        state       <= StMrsDllRst;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_cas_n <= 1'b0;
                        sdram_we_n  <= 1'b0;
                        sdram_adr   <= MrDllRst;
                        sdram_ba    <= 2'b00;
                        cnt         <= LdMrd;
                    end
                end

                StMrsDllRst: begin
                    if (cnt_zero) begin
                        state       <= StPre2;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_we_n  <= 1'b0;
                        sdram_adr   <= AdrPreAll;
                        sdram_ba    <= 2'b00;
                        cnt         <= LdRp;
                    end
                end

                StPre2: begin
                    if (cnt_zero) begin
                        state       <= StRef1;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_cas_n <= 1'b0;
                        cnt         <= LdRfc;
                    end
                end

                StRef1: begin
                    if (cnt_zero) begin
                        state       <= StRef2;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_cas_n <= 1'b0;
                        cnt         <= LdRfc;
                    end
                end

                StRef2: begin
                    if (cnt_zero) begin
                        state       <= StMrs;
                        sdram_cs_n  <= 1'b0;
                        sdram_ras_n <= 1'b0;
                        sdram_cas_n <= 1'b0;
                        sdram_we_n  <= 1'b0;
                        sdram_adr   <= MrRun;
                        sdram_ba    <= 2'b00;
                    end
                end

                // MRS lasts exactly one cycle; the DLL lock wait follows.
                StMrs: begin
                    if (TDll == 1) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= 16'd1;
                    end else begin
                        state <= StDllWait;
                        cnt   <= LdDll;
                    end
                end

                StDllWait: begin
                    if (cnt_zero) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= 16'd1;
                    end
                end

                // The counter is left at 1 on entry so a start sampled in the
                // cycle done rises is dropped; it is accepted from then on.
                StDone: begin
                    if (start && cnt_zero) begin
                        state     <= StPwrup;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        sdram_cke <= 1'b0;
                        cnt       <= LdPwrup;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpdmc_initseq.sv
module tb_hpdmc_initseq;

    localparam int M_PWR = 10, M_RP = 2, M_MRD = 2, M_RFC = 8, M_DLL = 200;
    localparam int Z_PWR = 0, Z_RP = 0, Z_MRD = 0, Z_RFC = 0, Z_DLL = 0;
    localparam logic [12:0] MR  = 13'h022;
    localparam logic [12:0] EMR = 13'h000;

    typedef struct packed {
        logic [6:0]  ctl;   // {busy, done, cke, cs_n, ras_n, cas_n, we_n}
        logic [12:0] adr;
        logic [1:0]  ba;
        logic        chk;   // adr/ba defined in this cycle
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic m_start = 1'b0, z_start = 1'b0;

    logic m_busy, m_done, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n;
    logic [12:0] m_adr;
    logic [1:0]  m_ba;
    logic z_busy, z_done, z_cke, z_cs_n, z_ras_n, z_cas_n, z_we_n;
    logic [12:0] z_adr;
    logic [1:0]  z_ba;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hpdmc_initseq #(
        .T_PWRUP(M_PWR), .T_RP(M_RP), .T_MRD(M_MRD), .T_RFC(M_RFC), .T_DLL(M_DLL),
        .MR_VAL(MR), .EMR_VAL(EMR)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(m_start),
        .busy(m_busy), .done(m_done), .sdram_cke(m_cke),
        .sdram_cs_n(m_cs_n), .sdram_ras_n(m_ras_n), .sdram_cas_n(m_cas_n),
        .sdram_we_n(m_we_n), .sdram_adr(m_adr), .sdram_ba(m_ba)
    );

    hpdmc_initseq #(
        .T_PWRUP(Z_PWR), .T_RP(Z_RP), .T_MRD(Z_MRD), .T_RFC(Z_RFC), .T_DLL(Z_DLL),
        .MR_VAL(MR), .EMR_VAL(EMR)
    ) dut_z (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(z_start),
        .busy(z_busy), .done(z_done), .sdram_cke(z_cke),
        .sdram_cs_n(z_cs_n), .sdram_ras_n(z_ras_n), .sdram_cas_n(z_cas_n),
        .sdram_we_n(z_we_n), .sdram_adr(z_adr), .sdram_ba(z_ba)
    );

    function automatic exp_t obs_m();
        exp_t o;
        o.ctl = {m_busy, m_done, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n};
        o.adr = m_adr;
        o.ba  = m_ba;
        o.chk = 1'b1;
        return o;
    endfunction

    function automatic exp_t obs_z();
        exp_t o;
        o.ctl = {z_busy, z_done, z_cke, z_cs_n, z_ras_n, z_cas_n, z_we_n};
        o.adr = z_adr;
        o.ba  = z_ba;
        o.chk = 1'b1;
        return o;
    endfunction

    function automatic int clamp1(int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Expected bus state k cycles after the start pulse cycle, from the command
    // schedule: CKE rises after the power-up time, the first PRECHARGE follows
    // two cycles later, then each command is spaced by its timing parameter.
    function automatic exp_t model(int k, int tp_i, int trp_i, int tmrd_i, int trfc_i,
                                   int tdll_i, logic [12:0] padr, logic [1:0] pba);
        int tp, trp, tmrd, trfc, tdll, dn;
        int t [7];
        logic [2:0]  code [7];
        logic [12:0] a [7];
        logic [1:0]  b [7];
        logic        is_ref [7];
        exp_t e;
        tp = clamp1(tp_i); trp = clamp1(trp_i); tmrd = clamp1(tmrd_i);
        trfc = clamp1(trfc_i); tdll = clamp1(tdll_i);
        t[0] = tp + 3;
        t[1] = t[0] + trp;
        t[2] = t[1] + tmrd;
        t[3] = t[2] + tmrd;
        t[4] = t[3] + trp;
        t[5] = t[4] + trfc;
        t[6] = t[5] + trfc;
        dn = t[6] + tdll;
        // {ras_n, cas_n, we_n}: PRE=010, REF=001, (E)MRS=000
        code[0] = 3'b010; a[0] = 13'h0400;         b[0] = 2'b00; is_ref[0] = 1'b0;
        code[1] = 3'b000; a[1] = EMR;              b[1] = 2'b01; is_ref[1] = 1'b0;
        code[2] = 3'b000; a[2] = MR | 13'h0100;    b[2] = 2'b00; is_ref[2] = 1'b0;
        code[3] = 3'b010; a[3] = 13'h0400;         b[3] = 2'b00; is_ref[3] = 1'b0;
        code[4] = 3'b001; a[4] = 13'h0000;         b[4] = 2'b00; is_ref[4] = 1'b1;
        code[5] = 3'b001; a[5] = 13'h0000;         b[5] = 2'b00; is_ref[5] = 1'b1;
        code[6] = 3'b000; a[6] = MR & ~13'h0100;   b[6] = 2'b00; is_ref[6] = 1'b0;
        e.ctl = {(k >= 1 && k < dn), (k >= dn), (k > tp), 4'b1111};
        e.adr = padr;
        e.ba  = pba;
        for (int i = 0; i < 7; i++) begin
            if (t[i] <= k && !is_ref[i]) begin
                e.adr = a[i];
                e.ba  = b[i];
            end
            if (t[i] == k) e.ctl[3:0] = {1'b0, code[i]};
        end
        // Address bits during the refresh stretch are not defined.
        e.chk = !(k >= t[4] && k < t[6]);
        return e;
    endfunction

    task automatic test_reset();
        exp_t o;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        o = obs_m();
        total++;
        if ({o.ctl, o.adr, o.ba} !== {7'b000_1111, 13'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_main: got %b/%h/%b want 0001111/0000/00", o.ctl, o.adr, o.ba);
        end
        o = obs_z();
        total++;
        if ({o.ctl, o.adr, o.ba} !== {7'b000_1111, 13'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_zero: got %b/%h/%b want 0001111/0000/00", o.ctl, o.adr, o.ba);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold();
        int n = $urandom_range(5, 20);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if ({m_busy, m_done, m_cke, m_cs_n, z_busy, z_done, z_cke, z_cs_n} !== 8'b0001_0001)
            begin
                bad++;
                $display("FAIL idle_hold: cycle %0d got %b want 00010001", i,
                         {m_busy, m_done, m_cke, m_cs_n, z_busy, z_done, z_cke, z_cs_n});
            end
        end
    endtask

    // Full run on the main instance with stray start pulses while busy and in
    // the cycle done rises; none of them may disturb the trace.
    task automatic test_sequence(input logic [12:0] padr, input logic [1:0] pba,
                                 input string name);
        exp_t e, o;
        int dn = M_PWR + 3 + 2 * M_RP + 2 * M_MRD + 2 * M_RFC + M_DLL;
        int s1 = 5, s2 = $urandom_range(1, dn - 1), s3 = $urandom_range(1, dn - 1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        for (int k = 1; k <= dn + 3; k++) begin
            e = model(k, M_PWR, M_RP, M_MRD, M_RFC, M_DLL, padr, pba);
            o = obs_m();
            total++;
            if (o.ctl !== e.ctl) begin
                bad++;
                $display("FAIL %s_ctl: k=%0d got %b want %b", name, k, o.ctl, e.ctl);
            end
            if (e.chk) begin
                total++;
                if ({o.adr, o.ba} !== {e.adr, e.ba}) begin
                    bad++;
                    $display("FAIL %s_adr: k=%0d got %h/%b want %h/%b", name, k,
                             o.adr, o.ba, e.adr, e.ba);
                end
            end
            m_start = (k == s1 || k == s2 || k == s3 || k == dn);
            @(negedge clk);
        end
        m_start = 1'b0;
    endtask

    task automatic test_rerun();
        repeat ($urandom_range(0, 10)) @(negedge clk);
        test_sequence(MR & ~13'h0100, 2'b00, "rerun");
    endtask

    task automatic test_zero_params();
        exp_t e, o;
        int dn = 1 + 3 + 6 + 1;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0;
        for (int k = 1; k <= dn + 2; k++) begin
            e = model(k, Z_PWR, Z_RP, Z_MRD, Z_RFC, Z_DLL, 13'd0, 2'd0);
            o = obs_z();
            total++;
            if (o.ctl !== e.ctl) begin
                bad++;
                $display("FAIL zero_ctl: k=%0d got %b want %b", k, o.ctl, e.ctl);
            end
            if (e.chk) begin
                total++;
                if ({o.adr, o.ba} !== {e.adr, e.ba}) begin
                    bad++;
                    $display("FAIL zero_adr: k=%0d got %h/%b want %h/%b", k,
                             o.adr, o.ba, e.adr, e.ba);
                end
            end
            @(negedge clk);
        end
    endtask

    // Reset lands asynchronously between the two refresh commands.
    task automatic test_reset_mid();
        int ref1 = M_PWR + 3 + 2 * M_RP + 2 * M_MRD;
        int kr = ref1 + $urandom_range(1, M_RFC - 1);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (kr - 1) @(negedge clk);
        total++;
        if ({m_busy, m_cke} !== 2'b11) begin
            bad++;
            $display("FAIL mid_prereset: got busy/cke %b want 11", {m_busy, m_cke});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({m_busy, m_done, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n} !== 7'b000_1111) begin
            bad++;
            $display("FAIL mid_reset: got %b want 0001111",
                     {m_busy, m_done, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if ({m_busy, m_cke, m_cs_n} !== 3'b001) begin
                bad++;
                $display("FAIL mid_after: cycle %0d got busy/cke/cs_n %b want 001", i,
                         {m_busy, m_cke, m_cs_n});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_sequence(13'd0, 2'd0, "seq");
        test_rerun();
        test_zero_params();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
